// File: rtl/chan_scan_ctrl.sv
// chan_scan_ctrl
// Scan sequencer for a 9-input, 16-bit channel multiplexer. On an accepted
// start it steps `sel` through every channel enabled in `mask`, lowest index
// first. For each channel it captures the mux output and offers it as one
// sample on a valid/ready stream. It also tracks the largest sample of the
// scan. While idle, `sel` is parked at an out-of-range code, so the mux
// returns all ones.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high
//   start      in   scan request, sampled only in IDLE
//   mask       in   channel enable (bit n = channel n), captured on start
//   sel        out  registered channel select to the mux
//   mux_data   in   mux output, combinational from sel
//   smp_valid  out  sample available
//   smp_ready  in   downstream accepts sample
//   smp_data   out  captured sample, stable while smp_valid
//   smp_chan   out  channel index of smp_data
//   busy       out  high from accepted start through the DONE cycle
//   done       out  one-cycle pulse at scan end
//   max_data   out  largest sample of the last/current scan
//   max_chan   out  channel of max_data, PARK_SEL if no sample taken
module chan_scan_ctrl #(
    parameter int         WIDTH    = 16,
    parameter int         NCH      = 9,
    parameter logic [3:0] PARK_SEL = 4'hF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NCH-1:0]   mask,
    output logic [3:0]       sel,
    input  logic [WIDTH-1:0] mux_data,
    output logic             smp_valid,
    input  logic             smp_ready,
    output logic [WIDTH-1:0] smp_data,
    output logic [3:0]       smp_chan,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] max_data,
    output logic [3:0]       max_chan
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [NCH-1:0]   mask_q, mask_q_n;
    logic [3:0]       sel_n;
    logic [WIDTH-1:0] smp_data_n;
    logic [3:0]       smp_chan_n;
    logic [WIDTH-1:0] max_data_n;
    logic [3:0]       max_chan_n;
    // Set once the first sample of a scan has been captured. The first sample
    // always becomes the maximum, even when it is zero.
    logic             taken, taken_n;
    logic [NCH-1:0]   remain;

    // Index of the lowest set bit. Callers guarantee that m is non-zero.
    function automatic logic [3:0] lowest(input logic [NCH-1:0] m);
        logic [3:0] r;
        r = 4'd0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) r = i[3:0];
        end
        return r;
    endfunction

    assign smp_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            mask_q   <= '0;
            sel      <= PARK_SEL;
            smp_data <= '0;
            smp_chan <= 4'd0;
            max_data <= '0;
            max_chan <= PARK_SEL;
            taken    <= 1'b0;
        end else begin
            state    <= state_n;
            mask_q   <= mask_q_n;
            sel      <= sel_n;
            smp_data <= smp_data_n;
            smp_chan <= smp_chan_n;
            max_data <= max_data_n;
            max_chan <= max_chan_n;
            taken    <= taken_n;
        end
    end

    always_comb begin
        state_n    = state;
        mask_q_n   = mask_q;
        sel_n      = sel;
        smp_data_n = smp_data;
        smp_chan_n = smp_chan;
        max_data_n = max_data;
        max_chan_n = max_chan;
        taken_n    = taken;
        remain     = mask_q & ~({{(NCH-1){1'b0}}, 1'b1} << sel);

        unique case (state)
            IDLE: begin
                sel_n = PARK_SEL;
                if (start) begin
                    mask_q_n   = mask;
                    max_data_n = '0;
                    max_chan_n = PARK_SEL;
                    taken_n    = 1'b0;
                    if (mask == '0) begin
                        state_n = DONE;
                    end else begin
                        sel_n   = lowest(mask);
                        state_n = SEL;
                    end
                end
            end
            // sel has been stable for a full cycle, so the mux output is settled.
            SEL: begin
                smp_data_n = mux_data;
                smp_chan_n = sel;
                taken_n    = 1'b1;
                // The comparison is strict, so on a tie the earlier (lower)
                // channel is kept.
                if (!taken || (mux_data > max_data)) begin
                    max_data_n = mux_data;
                    max_chan_n = sel;
                end
                state_n = HOLD;
            end
            HOLD: begin
                if (smp_ready) begin
                    mask_q_n = remain;
                    if (remain != '0) begin
                        sel_n   = lowest(remain);
                        state_n = SEL;
                    end else begin
                        sel_n   = PARK_SEL;
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_chan_scan_ctrl.sv
// Testbench for chan_scan_ctrl. It is driven by a per-cycle vector table for
// the full and stalled scans. Hand-written sequences cover an empty mask,
// maximum/tie tracking, ignored start/mask changes and reset in mid-handshake.
module tb_chan_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [8:0]  mask;
    logic [3:0]  sel;
    logic [15:0] mux_data;
    logic        smp_valid;
    logic        smp_ready;
    logic [15:0] smp_data;
    logic [3:0]  smp_chan;
    logic        busy;
    logic        done;
    logic [15:0] max_data;
    logic [3:0]  max_chan;

    logic [15:0] chdata [9];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Behavioural mux: 9 inputs; out-of-range select returns all ones.
    always_comb begin
        mux_data = 16'hFFFF;
        for (int i = 0; i < 9; i++) begin
            if (sel == i[3:0]) mux_data = chdata[i];
        end
    end

    chan_scan_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mask      (mask),
        .sel       (sel),
        .mux_data  (mux_data),
        .smp_valid (smp_valid),
        .smp_ready (smp_ready),
        .smp_data  (smp_data),
        .smp_chan  (smp_chan),
        .busy      (busy),
        .done      (done),
        .max_data  (max_data),
        .max_chan  (max_chan)
    );

    typedef struct {
        logic        rst;
        logic        start;
        logic [8:0]  mask;
        logic        ready;
        logic [3:0]  e_sel;
        logic        e_valid;
        logic        e_busy;
        logic        e_done;
        logic        chk_data;
        logic [15:0] e_data;
        logic [3:0]  e_chan;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic st, input logic [8:0] m, input logic rdy,
                       input logic [3:0] es, input logic ev, input logic eb, input logic ed,
                       input logic ck, input logic [15:0] edat, input logic [3:0] ech);
        vec_t v;
        v.rst = 1'b0; v.start = st; v.mask = m; v.ready = rdy;
        v.e_sel = es; v.e_valid = ev; v.e_busy = eb; v.e_done = ed;
        v.chk_data = ck; v.e_data = edat; v.e_chan = ech;
        vt.push_back(v);
    endtask

    task automatic set_ramp();
        for (int i = 0; i < 9; i++) chdata[i] = 16'h0100 * 16'(i + 1);
    endtask

    // Starts a scan with ready held high and waits for done (bounded).
    // cyc counts edges from the start edge (1) through the edge raising done.
    task automatic run_scan(input logic [8:0] m, output int cyc);
        start = 1'b1; mask = m; smp_ready = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("scan_done_seen", 32'(done), 32'd1);
    endtask

    initial begin
        int chs[3];
        int cyc;
        int hs_chan[$];
        int ndone;
        logic saw_done;
        logic found;
        logic [3:0] nxt;

        reset = 1'b1; start = 1'b0; mask = '0; smp_ready = 1'b0;
        set_ramp();

        // Table: full scan, ramp data, ready always high.
        add(1, 9'h1FF, 1, 4'd0, 0, 1, 0, 0, 16'h0, 4'd0);
        for (int n = 0; n < 9; n++) begin
            add(0, 9'h1FF, 1, 4'(n), 1, 1, 0, 1, 16'h0100 * 16'(n + 1), 4'(n));
            add(0, 9'h1FF, 1, (n < 8) ? 4'(n + 1) : 4'hF, 0, 1, (n == 8), 1,
                16'h0100 * 16'(n + 1), 4'(n));
        end
        add(0, 9'h1FF, 1, 4'hF, 0, 0, 0, 1, 16'h0900, 4'd8);

        // Table: mask 9'b100010100, ready low for 3 cycles per sample.
        chs = '{2, 4, 8};
        add(1, 9'h114, 0, 4'd2, 0, 1, 0, 0, 16'h0, 4'd0);
        for (int k = 0; k < 3; k++) begin
            nxt = (k < 2) ? 4'(chs[k + 1]) : 4'hF;
            for (int s = 0; s < 4; s++)
                add(0, 9'h114, 0, 4'(chs[k]), 1, 1, 0, 1, 16'h0100 * 16'(chs[k] + 1), 4'(chs[k]));
            add(0, 9'h114, 1, nxt, 0, 1, (k == 2), 1, 16'h0100 * 16'(chs[k] + 1), 4'(chs[k]));
        end
        add(0, 9'h114, 1, 4'hF, 0, 0, 0, 1, 16'h0900, 4'd8);

        // Reset state.
        tick(); tick();
        reset = 1'b0;
        chk("rst_sel", 32'(sel), 32'hF);
        chk("rst_valid", 32'(smp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_smp_data", 32'(smp_data), 32'd0);
        chk("rst_smp_chan", 32'(smp_chan), 32'd0);
        chk("rst_max_data", 32'(max_data), 32'd0);
        chk("rst_max_chan", 32'(max_chan), 32'hF);
        tick();

        // Apply the vector table.
        for (int i = 0; i < vt.size(); i++) begin
            reset = vt[i].rst; start = vt[i].start; mask = vt[i].mask; smp_ready = vt[i].ready;
            tick();
            chk($sformatf("v%0d_sel", i), 32'(sel), 32'(vt[i].e_sel));
            chk($sformatf("v%0d_valid", i), 32'(smp_valid), 32'(vt[i].e_valid));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(vt[i].e_done));
            if (vt[i].chk_data) begin
                chk($sformatf("v%0d_data", i), 32'(smp_data), 32'(vt[i].e_data));
                chk($sformatf("v%0d_chan", i), 32'(smp_chan), 32'(vt[i].e_chan));
            end
        end
        start = 1'b0;
        chk("tbl_max_data", 32'(max_data), 32'h0900);
        chk("tbl_max_chan", 32'(max_chan), 32'd8);

        // Empty mask: done right away, no sample, max cleared.
        start = 1'b1; mask = 9'h000; smp_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("m0_done", 32'(done), 32'd1);
        chk("m0_busy", 32'(busy), 32'd1);
        chk("m0_valid", 32'(smp_valid), 32'd0);
        chk("m0_sel", 32'(sel), 32'hF);
        chk("m0_max_data", 32'(max_data), 32'd0);
        chk("m0_max_chan", 32'(max_chan), 32'hF);
        tick();
        chk("m0_done_end", 32'(done), 32'd0);
        chk("m0_busy_end", 32'(busy), 32'd0);
        chk("m0_valid_end", 32'(smp_valid), 32'd0);
        chk("m0_sel_end", 32'(sel), 32'hF);

        // Max tracking with ties.
        for (int i = 0; i < 9; i++) chdata[i] = 16'h0000;
        chdata[1] = 16'h8000; chdata[5] = 16'h8000; chdata[7] = 16'hFFFE;
        run_scan(9'h1FF, cyc);
        tick();
        chk("tie_max_chan", 32'(max_chan), 32'd7);
        chk("tie_max_data", 32'(max_data), 32'hFFFE);
        chdata[7] = 16'h0000;
        run_scan(9'h1FF, cyc);
        tick();
        chk("tie2_max_chan", 32'(max_chan), 32'd1);
        chk("tie2_max_data", 32'(max_data), 32'h8000);
        // All-zero samples: the first sampled channel still becomes the max.
        for (int i = 0; i < 9; i++) chdata[i] = 16'h0000;
        run_scan(9'h1F0, cyc);
        tick();
        chk("zero_max_chan", 32'(max_chan), 32'd4);
        chk("zero_max_data", 32'(max_data), 32'd0);

        // start mid-scan and in the DONE cycle is ignored; mask changes are ignored.
        set_ramp();
        saw_done = 1'b0; ndone = 0;
        for (int i = 0; i < 30; i++) begin
            start = (i == 0) || (i == 5) || (i == 9) || saw_done;
            mask = (i == 0) ? 9'h1FF : 9'h0AA;
            smp_ready = 1'b1;
            if (smp_valid) hs_chan.push_back(int'(smp_chan));
            tick();
            saw_done = done;
            if (done) ndone++;
        end
        start = 1'b0;
        chk("ign_hs_count", 32'(hs_chan.size()), 32'd9);
        for (int k = 0; k < hs_chan.size() && k < 9; k++)
            chk($sformatf("ign_hs_chan%0d", k), 32'(hs_chan[k]), 32'(k));
        chk("ign_done_count", 32'(ndone), 32'd1);
        chk("ign_busy_end", 32'(busy), 32'd0);

        // Reset in HOLD on channel 3, mid-handshake.
        start = 1'b1; mask = 9'h1FF; smp_ready = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (smp_valid && smp_chan == 4'd3) found = 1'b1;
        end
        chk("rh_reach_ch3", 32'(found), 32'd1);
        reset = 1'b1; smp_ready = 1'b1;
        tick();
        reset = 1'b0;
        chk("rh_valid", 32'(smp_valid), 32'd0);
        chk("rh_busy", 32'(busy), 32'd0);
        chk("rh_done", 32'(done), 32'd0);
        chk("rh_sel", 32'(sel), 32'hF);
        chk("rh_max_chan", 32'(max_chan), 32'hF);
        chk("rh_max_data", 32'(max_data), 32'd0);
        chk("rh_smp_data", 32'(smp_data), 32'd0);
        chk("rh_smp_chan", 32'(smp_chan), 32'd0);
        tick();
        run_scan(9'h1FF, cyc);
        chk("rh_scan_cycles", 32'(cyc), 32'd19);
        chk("rh_scan_max_data", 32'(max_data), 32'h0900);
        chk("rh_scan_max_chan", 32'(max_chan), 32'd8);
        tick();
        chk("rh_scan_busy_end", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
